// File: rtl/split_pkg.sv
// split_pkg: shared definitions for the packet splitter.
//   ADDR_W_DEF / DATA_W_DEF / CNT_W_DEF : default field and counter widths
//   PKT_W_DEF                           : default packet width {addr, data}
//   pend_state_e                        : {addr_pend, data_pend} encoding
//   get_addr / get_data                 : field extraction for default-width packets
package split_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 7;
    localparam int CNT_W_DEF  = 16;
    localparam int PKT_W_DEF  = ADDR_W_DEF + DATA_W_DEF;

    // Bit 1 = address still owed downstream, bit 0 = data still owed.
    typedef enum logic [1:0] {
        EMPTY     = 2'b00,
        DATA_ONLY = 2'b01,
        ADDR_ONLY = 2'b10,
        BOTH      = 2'b11
    } pend_state_e;

    // Address lives in the packet MSBs.
    function automatic logic [ADDR_W_DEF-1:0] get_addr(input logic [PKT_W_DEF-1:0] pkt);
        return ADDR_W_DEF'(pkt >> DATA_W_DEF);
    endfunction

    // Data lives in the packet LSBs.
    function automatic logic [DATA_W_DEF-1:0] get_data(input logic [PKT_W_DEF-1:0] pkt);
        return DATA_W_DEF'(pkt);
    endfunction

endpackage

// File: rtl/split_out_slot.sv
// split_out_slot: one-entry output register with valid/ready handshake.
// Holds a single field until its consumer takes it.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   load_i       : capture din_i (only asserted when done_o is high)
//   din_i        : field value to capture
//   ready_i      : downstream consumer ready
//   valid_o      : field pending downstream
//   dout_o       : held field value (stable while valid_o & ~ready_i)
//   done_o       : slot is free or being emptied this cycle
module split_out_slot #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] din_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] dout_o,
    output logic         done_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q,  data_d;

    // A load always wins: the top only loads when this slot is done, so
    // a same-cycle handshake and reload replaces the old value cleanly.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = din_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign dout_o  = data_q;
    assign done_o  = ~valid_q | ready_i;

endmodule

// File: rtl/split_module.sv
// split_module: forks one {addr, data} packet onto independent address and
// data output channels. A packet is accepted only when both halves of the
// previous packet have been (or are being) delivered, so back-to-back
// packets stream at one per cycle when both consumers are ready.
//
// Handshake rule on every channel: a transfer happens on the rising edge
// where valid & ready are both high; a raised valid never drops and its
// payload never changes until that transfer.
//
// Ports:
//   CLK, RESET             : clock, asynchronous active-high reset
//   in_valid/in_ready      : input packet channel, in_pkt = {addr, data}
//   addr_valid/addr_ready  : address output channel, addr_out
//   data_valid/data_ready  : data output channel, data_out
//   state_dbg_o            : current {addr_pend, data_pend} state
//   pkt_count              : packets fully delivered (SPLIT_PKT_CNT_EN only)
//
// Build option: define SPLIT_PKT_CNT_EN to add the wrapping CNT_W-bit
// delivered-packet counter and its pkt_count port.
module split_module
    import split_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
`ifdef SPLIT_PKT_CNT_EN
    , parameter int CNT_W = CNT_W_DEF
`endif
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W+DATA_W-1:0] in_pkt,
    output logic                     addr_valid,
    input  logic                     addr_ready,
    output logic [ADDR_W-1:0]        addr_out,
    output logic                     data_valid,
    input  logic                     data_ready,
    output logic [DATA_W-1:0]        data_out,
    output pend_state_e              state_dbg_o
`ifdef SPLIT_PKT_CNT_EN
    , output logic [CNT_W-1:0]       pkt_count
`endif
);

    localparam int PKT_W = ADDR_W + DATA_W;

    logic [ADDR_W-1:0] addr_fld;
    logic [DATA_W-1:0] data_fld;
    logic              addr_done;
    logic              data_done;
    logic              accept;

    // The package helpers are fixed to the default widths; other widths
    // fall back to direct slicing of the same field layout.
    generate
        if (ADDR_W == ADDR_W_DEF && DATA_W == DATA_W_DEF) begin : g_pkg_fields
            assign addr_fld = get_addr(in_pkt);
            assign data_fld = get_data(in_pkt);
        end else begin : g_slice_fields
            assign addr_fld = in_pkt[PKT_W-1 -: ADDR_W];
            assign data_fld = in_pkt[DATA_W-1:0];
        end
    endgenerate

    // Held low during reset so nothing is accepted while state is cleared.
    assign in_ready = addr_done & data_done & ~RESET;
    assign accept   = in_valid & in_ready;

    split_out_slot #(.W(ADDR_W)) u_addr_slot (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .load_i  (accept),
        .din_i   (addr_fld),
        .ready_i (addr_ready),
        .valid_o (addr_valid),
        .dout_o  (addr_out),
        .done_o  (addr_done)
    );

    split_out_slot #(.W(DATA_W)) u_data_slot (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .load_i  (accept),
        .din_i   (data_fld),
        .ready_i (data_ready),
        .valid_o (data_valid),
        .dout_o  (data_out),
        .done_o  (data_done)
    );

    // The pending bits live in the two slots; this is their state view.
    always_comb begin
        state_dbg_o = pend_state_e'({addr_valid, data_valid});
    end

`ifdef SPLIT_PKT_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pkt_done;

    // Something is still owed and everything owed goes out this cycle:
    // the last outstanding half of the current packet is handshaking.
    assign pkt_done = (addr_valid | data_valid) & addr_done & data_done;

    always_comb begin
        cnt_d = cnt_q;
        if (pkt_done) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign pkt_count = cnt_q;
`endif

endmodule
